// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset PC default, NOP encoding and fetch FSM states.
package inst_fetch_pkg;
    localparam int BUS_W = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory, redirect and decode handshake signals of the fetch stage.
interface inst_fetch_if #(parameter int BUS_W = 32);
    logic [BUS_W-1:0] imAddrOut;
    logic [BUS_W-1:0] imInstIn;
    logic             redirect_valid;
    logic [BUS_W-1:0] redirect_pc;
    logic             if_valid;
    logic [BUS_W-1:0] if_inst;
    logic [BUS_W-1:0] if_pc;
    logic             id_ready;
    modport master (
        output imAddrOut, if_valid, if_inst, if_pc,
        input  imInstIn, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imAddrOut, if_valid, if_inst, if_pc,
        output imInstIn, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {inst, pc} entries with synchronous flush; flush wins over enqueue.
module fetch_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         enq_i,
    input  logic [W-1:0] enq_data_i,
    input  logic         deq_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_enq, do_deq;
    assign valid_o = count_q != '0;
    assign full_o  = count_q == CW'(DEPTH);
    assign head_o  = mem_q[head_q];
    assign do_deq  = deq_i && valid_o;
    assign do_enq  = enq_i && !flush_i && (!full_o || do_deq);
    always_comb begin
        head_d  = flush_i ? '0 : head_q + PW'(do_deq);
        tail_d  = flush_i ? '0 : tail_q + PW'(do_enq);
        count_d = flush_i ? '0 : count_q + CW'(do_enq) - CW'(do_deq);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // storage is never cleared; count alone decides what is live
    always_ff @(posedge clk) begin
        if (do_enq) mem_q[tail_q] <= enq_data_i;
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC/FSM front end feeding a fetch queue toward decode.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise sticky fetch_misalign.
module inst_fetch #(
    parameter int               BUS_W    = inst_fetch_pkg::BUS_W,
    parameter logic [BUS_W-1:0] RESET_PC = inst_fetch_pkg::RESET_PC_DEF,
    parameter int               FQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus,
    output logic         fetch_misalign
);
    import inst_fetch_pkg::*;
    state_e             state_q, state_d;
    logic [BUS_W-1:0]   pc_q, pc_d, redir_pc;
    logic               redir_bad, fetch, deq, full, valid;
    logic [2*BUS_W-1:0] head;
    assign deq   = valid && bus.id_ready;
    assign fetch = state_q == RUN && !bus.redirect_valid && (!full || deq);
`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign redir_pc       = bus.redirect_pc;
    assign redir_bad      = |bus.redirect_pc[1:0];
    assign mis_d          = bus.redirect_valid ? redir_bad : mis_q;
    assign fetch_misalign = mis_q;
    always_ff @(posedge clk) begin
        mis_q <= !rst_n ? 1'b0 : mis_d;
    end
`else
    assign redir_pc       = bus.redirect_pc & ~BUS_W'(3);
    assign redir_bad      = 1'b0;
    assign fetch_misalign = 1'b0;
`endif
    always_comb begin
        state_d = state_q == BOOT ? RUN : state_q;
        pc_d    = fetch ? pc_q + BUS_W'(4) : pc_q;
        if (bus.redirect_valid) begin
            state_d = redir_bad ? HALT : RUN;
            pc_d    = redir_pc;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    fetch_queue #(.W(2 * BUS_W), .DEPTH(FQ_DEPTH)) u_fq (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (bus.redirect_valid),
        .enq_i      (fetch),
        .enq_data_i ({bus.imInstIn, pc_q}),
        .deq_i      (deq),
        .head_o     (head),
        .valid_o    (valid),
        .full_o     (full)
    );
    assign bus.imAddrOut = pc_q;
    assign bus.if_valid  = valid;
    assign bus.if_pc     = head[BUS_W-1:0];
    assign bus.if_inst   = valid ? head[2*BUS_W-1:BUS_W] : BUS_W'(NOP);
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a queue-level reference model.
module tb_inst_fetch;
    localparam logic [31:0] KEY = 32'hC0DE_5A5A;
    localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fetch_misalign;
    int checks = 0;
    int errors = 0;
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit m_boot, m_halt, m_mis;

    inst_fetch_if #(.BUS_W(32)) bus ();
    inst_fetch #(.BUS_W(32), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fetch_misalign(fetch_misalign)
    );
    always #5 clk = ~clk;
    assign bus.imInstIn = bus.imAddrOut ^ KEY;

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_pc = 32'h0;
            m_boot = 1;
            m_halt = 0;
            m_mis = 0;
        end else if (bus.redirect_valid) begin
            mq.delete();
            m_halt = MIS_EN && (bus.redirect_pc[1:0] != 2'b00);
            m_mis = m_halt;
            m_pc = MIS_EN ? bus.redirect_pc : (bus.redirect_pc & ~32'd3);
            m_boot = 0;
        end else begin
            if (mq.size() != 0 && bus.id_ready) void'(mq.pop_front());
            if (!m_boot && !m_halt && mq.size() < DEPTH) begin
                mq.push_back({m_pc ^ KEY, m_pc});
                m_pc = m_pc + 32'd4;
            end
            m_boot = 0;
        end
        #1;
    endtask

    function automatic logic [97:0] exp_vec();
        logic [63:0] h;
        logic v;
        v = mq.size() != 0;
        h = '0;
        if (v) h = mq[0];
        return {v, h[31:0], h[63:32], m_pc, m_mis};
    endfunction

    function automatic logic [97:0] obs_vec();
        logic v;
        v = bus.if_valid;
        return {v, v ? bus.if_pc : 32'h0, v ? bus.if_inst : 32'h0, bus.imAddrOut, fetch_misalign};
    endfunction

    task automatic test_reset();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec()); end
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imAddrOut !== 32'h0) begin
            errors++; $display("FAIL reset_state: valid=%b addr=%h expected valid=0 addr=00000000", bus.if_valid, bus.imAddrOut);
        end
    endtask

    task automatic test_stream();
        logic [31:0] nxt = 32'h0;
        rst_n = 1;
        bus.id_ready = 1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL stream_model cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
            checks++;
            if (bus.if_valid !== (i >= 2)) begin errors++; $display("FAIL stream_valid cyc%0d: got %b expected %b", i, bus.if_valid, i >= 2); end
            if (bus.if_valid === 1'b1) begin
                checks++;
                if (bus.if_pc !== nxt) begin errors++; $display("FAIL stream_pc cyc%0d: got %h expected %h", i, bus.if_pc, nxt); end
                nxt = nxt + 32'd4;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] nxt = 32'h0;
        rst_n = 0;
        bus.id_ready = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL stall_model cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
            tick();
        end
        checks++;
        if (bus.if_valid !== 1'b1 || bus.imAddrOut !== 32'h8 || bus.if_pc !== 32'h0) begin
            errors++; $display("FAIL stall_hold: valid=%b addr=%h pc=%h expected 1/00000008/00000000", bus.if_valid, bus.imAddrOut, bus.if_pc);
        end
        bus.id_ready = 1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== nxt) begin
                errors++; $display("FAIL stall_drain cyc%0d: valid=%b pc=%h expected 1/%h", i, bus.if_valid, bus.if_pc, nxt);
            end
            nxt = nxt + 32'd4;
            tick();
        end
    endtask

    task automatic test_redirect();
        bus.id_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL redir_full_model: got %h expected %h", obs_vec(), exp_vec()); end
        bus.redirect_valid = 1;
        bus.redirect_pc = 32'h100;
        bus.id_ready = 1;
        tick();
        bus.redirect_valid = 0;
        checks++;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: valid=%b expected 0", bus.if_valid); end
        tick();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100) begin
            errors++; $display("FAIL redir_target: valid=%b pc=%h expected 1/00000100", bus.if_valid, bus.if_pc);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL redir_model: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_wrap();
        logic [31:0] nxt = 32'hFFFF_FFF8;
        bit seen_zero = 0;
        bus.redirect_valid = 1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL wrap_model cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
            if (bus.if_valid === 1'b1) begin
                checks++;
                if (bus.if_pc !== nxt) begin errors++; $display("FAIL wrap_pc cyc%0d: got %h expected %h", i, bus.if_pc, nxt); end
                if (bus.if_pc === 32'h0) seen_zero = 1;
                nxt = nxt + 32'd4;
            end
            tick();
        end
        checks++;
        if (!seen_zero) begin errors++; $display("FAIL wrap_zero: pc 00000000 seen=%b expected 1", seen_zero); end
    endtask

    task automatic test_misalign();
        bus.id_ready = 1;
        bus.redirect_valid = 1;
        bus.redirect_pc = 32'h102;
        tick();
        bus.redirect_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fetch_misalign !== 1'b1 || bus.if_valid !== 1'b0) begin
                errors++; $display("FAIL mis_halt cyc%0d: flag=%b valid=%b expected 1/0", i, fetch_misalign, bus.if_valid);
            end
            tick();
        end
        bus.redirect_valid = 1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect_valid = 0;
        checks++;
        if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: flag=%b expected 0", fetch_misalign); end
        tick();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200) begin
            errors++; $display("FAIL mis_resume: valid=%b pc=%h expected 1/00000200", bus.if_valid, bus.if_pc);
        end
`else
        tick();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || fetch_misalign !== 1'b0) begin
            errors++; $display("FAIL mis_align: valid=%b pc=%h flag=%b expected 1/00000100/0", bus.if_valid, bus.if_pc, fetch_misalign);
        end
`endif
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL mis_model: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_reset_mid();
        bus.id_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: valid=%b expected 1", bus.if_valid); end
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imAddrOut !== 32'h0) begin
            errors++; $display("FAIL rstmid_state: valid=%b addr=%h expected 0/00000000", bus.if_valid, bus.imAddrOut);
        end
        bus.id_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL rstmid_model cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            bus.id_ready = $urandom_range(0, 9) < 7;
            bus.redirect_valid = $urandom_range(0, 19) == 0;
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) rpc[31:8] = 24'hFFFFFF;
            bus.redirect_pc = rpc;
            rst_n = $urandom_range(0, 99) != 0;
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random_model cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
            tick();
        end
        rst_n = 1;
        bus.redirect_valid = 0;
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random_final: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    initial begin
        bus.id_ready = 0;
        bus.redirect_valid = 0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: BUS_W, 32, address/data width; matches codebase `BUS_W.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter: FQ_DEPTH, 2, fetch-queue entries (power of two, >=2).
REQ-004 Port: clk  in  1  single clock; all state changes on posedge.
REQ-005 Port: rst_n  in  1  synchronous, active-low reset.
REQ-006 Port: imAddrOut  out  BUS_W  byte fetch address to instruction memory.
REQ-007 Port: imInstIn  in  BUS_W  instruction word from memory; combinational, same cycle as imAddrOut.
REQ-008 Port: redirect_valid  in  1  branch/jump/trap redirect request.
REQ-009 Port: redirect_pc  in  BUS_W  redirect target.
REQ-010 Port: if_valid  out  1  queue head holds a valid instruction.
REQ-011 Port: if_inst  out  BUS_W  queue-head instruction.
REQ-012 Port: if_pc  out  BUS_W  queue-head PC.
REQ-013 Port: id_ready  in  1  decode accepts head; transfer when if_valid && id_ready.
REQ-014 Port: fetch_misalign  out  1  sticky misaligned-redirect flag (FETCH_MISALIGN_TRAP_EN only; tied 0 otherwise).

Function
REQ-015 FSM states BOOT, RUN, HALT; reset enters BOOT; BOOT -> RUN unconditionally next cycle; no fetch in BOOT.
REQ-016 imAddrOut SHALL equal the PC register at all times.
REQ-017 In RUN, enqueue {imInstIn, pc} and pc <= pc+4 when count<FQ_DEPTH, or count==FQ_DEPTH with a dequeue in the same cycle.
REQ-018 PC increment wraps modulo 2^BUS_W (32'hFFFF_FFFC -> 0).
REQ-019 Queue is circular, head/tail pointers log2(FQ_DEPTH) bits, count 0..FQ_DEPTH; simultaneous enqueue and dequeue leaves count unchanged.
REQ-020 if_valid = (count!=0); if_inst/if_pc driven from head entry; they hold stable while if_valid && !id_ready.
REQ-021 Latency: instruction fetched in cycle N appears on if_inst in cycle N+1 (no bypass).
REQ-022 redirect_valid has priority: queue flushed (count<=0, pointers<=0), pc <= redirect_pc, same-cycle enqueue discarded; a same-cycle dequeue still counts as consumed by decode.
REQ-023 After redirect in cycle N, first new-path instruction is on if_inst in cycle N+2 with if_pc == redirect_pc.
REQ-024 Redirect in BOOT loads pc and still transitions to RUN.
REQ-025 Queue full and no dequeue: pc and imAddrOut hold.

Reset
REQ-026 On clk edge with rst_n==0: pc<=RESET_PC, count/head/tail<=0, state<=BOOT, fetch_misalign<=0; hence imAddrOut==RESET_PC, if_valid==0.
REQ-027 Reset mid-operation discards all queue contents; queue storage data need not be cleared.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_misalign, flushes queue, enters HALT (no fetch); a later aligned redirect clears fetch_misalign and returns to RUN.
REQ-029 Macro undefined: redirect_pc[1:0] forced to 0 when loaded; HALT state unreachable; fetch_misalign tied 0.

Structure
REQ-030 Shared package/include holds BUS_W, NOP encoding, FSM state encodings, RESET_PC default.
REQ-031 One sub-module fetch_queue (parametric FIFO with flush) instantiated once; PC/FSM logic in inst_fetch.

Verification
REQ-032 Reset, id_ready=1, memory returns addr-tagged words -> if_pc 0,4,8,... consecutive from cycle 2 after rst_n rises.
REQ-033 id_ready=0 for 5 cycles -> count saturates at 2, imAddrOut holds at 8, if_pc stays 0; id_ready=1 -> 0,4,8 delivered without gaps or duplicates.
REQ-034 redirect_valid with redirect_pc=32'h100 while queue full -> if_valid 0 next cycle, if_pc==32'h100 two cycles after redirect.
REQ-035 pc=32'hFFFF_FFFC -> next if_pc 32'h0000_0000.
REQ-036 With FETCH_MISALIGN_TRAP_EN: redirect 32'h102 -> fetch_misalign=1, if_valid stays 0; redirect 32'h200 -> flag clears, if_pc 32'h200 delivered. Without macro: 32'h102 -> if_pc 32'h100.
REQ-037 rst_n low for one cycle while queue holds 2 entries -> if_valid 0, imAddrOut==RESET_PC next cycle.
